// File: rtl/param_parser.sv
// Run-time programmable header-chain parser: walks one header per cycle from ID 0
// and reports per-header offsets, a valid bitmap, the parsed length and an error code.
module param_parser #(
  parameter int HDR_MAX_LEN     = 128,
  parameter int NUM_HEADERS     = 8,
  parameter int NEXT_TABLE_SIZE = 4,
  parameter int TAG_BYTES       = 2,
  localparam int ADDR_W = $clog2(HDR_MAX_LEN + 1),
  localparam int ID_W   = $clog2(NUM_HEADERS),
  localparam int TAG_W  = 8 * TAG_BYTES
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        start_i,
  input  logic [HDR_MAX_LEN-1:0][7:0]                 pkt_hdr_i,
  output logic                                        busy_o,
  output logic                                        done_o,
  output logic [NUM_HEADERS-1:0]                      hdr_valid_o,
  output logic [NUM_HEADERS-1:0][ADDR_W-1:0]          hdr_offset_o,
  output logic [ADDR_W-1:0]                           parsed_len_o,
  output logic                                        err_o,
  output logic [1:0]                                  err_code_o,
  input  logic                                        cfg_we_i,
  input  logic [ID_W-1:0]                             cfg_hdr_id_i,
  input  logic [ADDR_W-1:0]                           cfg_hdr_len_i,
  input  logic [ADDR_W-1:0]                           cfg_tag_start_i,
  input  logic [2:0]                                  cfg_tag_len_i,
  input  logic [NEXT_TABLE_SIZE-1:0]                  cfg_entry_valid_i,
  input  logic [NEXT_TABLE_SIZE-1:0][TAG_W-1:0]       cfg_entry_tag_i,
  input  logic [NEXT_TABLE_SIZE-1:0][ID_W-1:0]        cfg_entry_next_i,
  output logic                                        cfg_ack_o
);

  typedef enum logic [1:0] {IDLE, PARSE, DONE} state_t;

  localparam int              BYTE_W  = $clog2(HDR_MAX_LEN);
  localparam logic [ADDR_W:0] MAX_LEN = (ADDR_W + 1)'(HDR_MAX_LEN);

  state_t                                 state_q, state_d;
  logic [ID_W-1:0]                        cur_id_q, cur_id_d;
  logic [ADDR_W-1:0]                      cur_off_q, cur_off_d;
  logic [NUM_HEADERS-1:0]                 hdr_valid_q, hdr_valid_d;
  logic [NUM_HEADERS-1:0][ADDR_W-1:0]     hdr_offset_q, hdr_offset_d;
  logic [ADDR_W-1:0]                      parsed_len_q, parsed_len_d;
  logic                                   err_q, err_d;
  logic [1:0]                             err_code_q, err_code_d;
  logic                                   cfg_ack_q, cfg_ack_d;

  logic [NUM_HEADERS-1:0][ADDR_W-1:0]                         hdr_len_q, hdr_len_d;
  logic [NUM_HEADERS-1:0][ADDR_W-1:0]                         tag_start_q, tag_start_d;
  logic [NUM_HEADERS-1:0][2:0]                                tag_len_q, tag_len_d;
  logic [NUM_HEADERS-1:0][NEXT_TABLE_SIZE-1:0]                entry_valid_q, entry_valid_d;
  logic [NUM_HEADERS-1:0][NEXT_TABLE_SIZE-1:0][TAG_W-1:0]     entry_tag_q, entry_tag_d;
  logic [NUM_HEADERS-1:0][NEXT_TABLE_SIZE-1:0][ID_W-1:0]      entry_next_q, entry_next_d;

  logic [ADDR_W-1:0] cur_len, cur_tstart;
  logic [2:0]        cur_tlen;
  logic [ADDR_W:0]   hdr_end, tag_end, byte_idx;
  logic              oob, hit;
  logic [TAG_W-1:0]  tag_val;
  logic [ID_W-1:0]   hit_next;

  // Sums are one bit wider than ADDR_W so the bounds compare cannot wrap.
  always_comb begin
    cur_len    = hdr_len_q[cur_id_q];
    cur_tstart = tag_start_q[cur_id_q];
    cur_tlen   = tag_len_q[cur_id_q];
    hdr_end    = {1'b0, cur_off_q} + {1'b0, cur_len};
    tag_end    = {1'b0, cur_tstart} + (ADDR_W + 1)'(cur_tlen);
    oob        = (hdr_end > MAX_LEN) || ((cur_tlen != 3'd0) && (tag_end > {1'b0, cur_len}));
    tag_val    = '0;
    byte_idx   = '0;
    for (int j = 0; j < TAG_BYTES; j++) begin
      byte_idx = {1'b0, cur_off_q} + {1'b0, cur_tstart} + (ADDR_W + 1)'(j);
      if ((j < int'(cur_tlen)) && (byte_idx < MAX_LEN))
        tag_val = (tag_val << 8) | TAG_W'(pkt_hdr_i[byte_idx[BYTE_W-1:0]]);
    end
    hit      = 1'b0;
    hit_next = '0;
    // Scan downwards so the lowest-index matching entry is the one that sticks.
    for (int e = NEXT_TABLE_SIZE - 1; e >= 0; e--) begin
      if (entry_valid_q[cur_id_q][e] && (entry_tag_q[cur_id_q][e] == tag_val)) begin
        hit      = 1'b1;
        hit_next = entry_next_q[cur_id_q][e];
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    cur_id_d      = cur_id_q;
    cur_off_d     = cur_off_q;
    hdr_valid_d   = hdr_valid_q;
    hdr_offset_d  = hdr_offset_q;
    parsed_len_d  = parsed_len_q;
    err_d         = err_q;
    err_code_d    = err_code_q;
    cfg_ack_d     = 1'b0;
    hdr_len_d     = hdr_len_q;
    tag_start_d   = tag_start_q;
    tag_len_d     = tag_len_q;
    entry_valid_d = entry_valid_q;
    entry_tag_d   = entry_tag_q;
    entry_next_d  = entry_next_q;

    case (state_q)
      IDLE: begin
        if (cfg_we_i) begin
          hdr_len_d[cfg_hdr_id_i]     = cfg_hdr_len_i;
          tag_start_d[cfg_hdr_id_i]   = cfg_tag_start_i;
          tag_len_d[cfg_hdr_id_i]     = cfg_tag_len_i;
          entry_valid_d[cfg_hdr_id_i] = cfg_entry_valid_i;
          entry_tag_d[cfg_hdr_id_i]   = cfg_entry_tag_i;
          entry_next_d[cfg_hdr_id_i]  = cfg_entry_next_i;
          cfg_ack_d                   = 1'b1;
        end else if (start_i) begin
          hdr_valid_d  = '0;
          hdr_offset_d = '0;
          parsed_len_d = '0;
          err_d        = 1'b0;
          err_code_d   = 2'd0;
          cur_id_d     = '0;
          cur_off_d    = '0;
          state_d      = PARSE;
        end
      end
      PARSE: begin
        if (hdr_valid_q[cur_id_q]) begin
          err_d      = 1'b1;
          err_code_d = 2'd2;
          state_d    = DONE;
        end else if (cur_len == '0) begin
          err_d      = 1'b1;
          err_code_d = 2'd3;
          state_d    = DONE;
        end else if (oob) begin
          err_d      = 1'b1;
          err_code_d = 2'd1;
          state_d    = DONE;
        end else begin
          hdr_valid_d[cur_id_q]  = 1'b1;
          hdr_offset_d[cur_id_q] = cur_off_q;
          parsed_len_d           = hdr_end[ADDR_W-1:0];
          if ((cur_tlen != 3'd0) && hit) begin
            cur_id_d  = hit_next;
            cur_off_d = hdr_end[ADDR_W-1:0];
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cur_id_q      <= '0;
      cur_off_q     <= '0;
      hdr_valid_q   <= '0;
      hdr_offset_q  <= '0;
      parsed_len_q  <= '0;
      err_q         <= 1'b0;
      err_code_q    <= 2'd0;
      cfg_ack_q     <= 1'b0;
      hdr_len_q     <= '0;
      tag_start_q   <= '0;
      tag_len_q     <= '0;
      entry_valid_q <= '0;
      entry_tag_q   <= '0;
      entry_next_q  <= '0;
    end else begin
      state_q       <= state_d;
      cur_id_q      <= cur_id_d;
      cur_off_q     <= cur_off_d;
      hdr_valid_q   <= hdr_valid_d;
      hdr_offset_q  <= hdr_offset_d;
      parsed_len_q  <= parsed_len_d;
      err_q         <= err_d;
      err_code_q    <= err_code_d;
      cfg_ack_q     <= cfg_ack_d;
      hdr_len_q     <= hdr_len_d;
      tag_start_q   <= tag_start_d;
      tag_len_q     <= tag_len_d;
      entry_valid_q <= entry_valid_d;
      entry_tag_q   <= entry_tag_d;
      entry_next_q  <= entry_next_d;
    end
  end

  assign busy_o       = (state_q == PARSE);
  assign done_o       = (state_q == DONE);
  assign hdr_valid_o  = hdr_valid_q;
  assign hdr_offset_o = hdr_offset_q;
  assign parsed_len_o = parsed_len_q;
  assign err_o        = err_q;
  assign err_code_o   = err_code_q;
  assign cfg_ack_o    = cfg_ack_q;

endmodule

// File: tb/tb_param_parser.sv
// Bench for param_parser: a 128-byte instance driven by a vector table and a done-time
// scoreboard, plus a 32-byte instance for the out-of-bounds chain.
module tb_param_parser;

  localparam int ADDR_W   = 8;
  localparam int S_ADDR_W = 6;
  localparam int ID_W     = 3;
  localparam int TAG_W    = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic                         start = 1'b0, start_s = 1'b0;
  logic [127:0][7:0]            pkt = '0;
  logic [31:0][7:0]             pkt_s;
  logic                         cfg_we = 1'b0;
  logic [ID_W-1:0]              cfg_id = '0;
  logic [ADDR_W-1:0]            cfg_len = '0, cfg_ts = '0;
  logic [2:0]                   cfg_tl = '0;
  logic [3:0]                   cfg_v = '0;
  logic [3:0][TAG_W-1:0]        cfg_tag = '0;
  logic [3:0][ID_W-1:0]         cfg_nxt = '0;

  logic                         busy_o, done_o, err_o, cfg_ack_o;
  logic [7:0]                   hdr_valid_o;
  logic [7:0][ADDR_W-1:0]       hdr_offset_o;
  logic [ADDR_W-1:0]            parsed_len_o;
  logic [1:0]                   err_code_o;

  logic                         busy_s, done_s, err_s, cfg_ack_s;
  logic [7:0]                   valid_s;
  logic [7:0][S_ADDR_W-1:0]     offs_s;
  logic [S_ADDR_W-1:0]          len_s;
  logic [1:0]                   code_s;

  assign pkt_s = pkt[31:0];

  param_parser dut (
    .clk(clk), .rst(rst), .start_i(start), .pkt_hdr_i(pkt),
    .busy_o(busy_o), .done_o(done_o), .hdr_valid_o(hdr_valid_o),
    .hdr_offset_o(hdr_offset_o), .parsed_len_o(parsed_len_o),
    .err_o(err_o), .err_code_o(err_code_o),
    .cfg_we_i(cfg_we), .cfg_hdr_id_i(cfg_id), .cfg_hdr_len_i(cfg_len),
    .cfg_tag_start_i(cfg_ts), .cfg_tag_len_i(cfg_tl), .cfg_entry_valid_i(cfg_v),
    .cfg_entry_tag_i(cfg_tag), .cfg_entry_next_i(cfg_nxt), .cfg_ack_o(cfg_ack_o)
  );

  param_parser #(.HDR_MAX_LEN(32)) dut_s (
    .clk(clk), .rst(rst), .start_i(start_s), .pkt_hdr_i(pkt_s),
    .busy_o(busy_s), .done_o(done_s), .hdr_valid_o(valid_s),
    .hdr_offset_o(offs_s), .parsed_len_o(len_s),
    .err_o(err_s), .err_code_o(code_s),
    .cfg_we_i(cfg_we), .cfg_hdr_id_i(cfg_id), .cfg_hdr_len_i(cfg_len[S_ADDR_W-1:0]),
    .cfg_tag_start_i(cfg_ts[S_ADDR_W-1:0]), .cfg_tag_len_i(cfg_tl), .cfg_entry_valid_i(cfg_v),
    .cfg_entry_tag_i(cfg_tag), .cfg_entry_next_i(cfg_nxt), .cfg_ack_o(cfg_ack_s)
  );

  typedef struct {
    logic [7:0]  valid;
    logic [63:0] offs;
    logic [7:0]  len;
    logic        err;
    logic [1:0]  code;
    int          lat;
    int          st;
  } exp_t;

  typedef struct {
    logic [7:0] b12, b13, b23;
    bit         restart;
    exp_t       e;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done_o) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done at cycle %0d", cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("hdr_valid", hdr_valid_o, e.valid);
        chk("hdr_offset", hdr_offset_o, e.offs);
        chk("parsed_len", parsed_len_o, e.len);
        chk("err", err_o, e.err);
        chk("err_code", err_code_o, e.code);
        chk("latency", 64'(cyc - e.st), 64'(e.lat));
        chk("busy_at_done", busy_o, 1'b0);
      end
    end
  end

  task automatic cfg_write(input logic [ID_W-1:0] id, input logic [7:0] len, input logic [7:0] ts,
                           input logic [2:0] tl, input logic [3:0] v,
                           input logic [3:0][TAG_W-1:0] tags, input logic [3:0][ID_W-1:0] nxt);
    @(negedge clk);
    cfg_id = id; cfg_len = len; cfg_ts = ts; cfg_tl = tl; cfg_v = v; cfg_tag = tags; cfg_nxt = nxt;
    cfg_we = 1'b1;
    @(negedge clk);
    cfg_we = 1'b0;
    chk("cfg_ack", cfg_ack_o, 1'b1);
    chk("cfg_ack_small", cfg_ack_s, 1'b1);
    @(negedge clk);
    chk("cfg_ack_pulse", cfg_ack_o, 1'b0);
  endtask

  task automatic fill_pkt(input logic [7:0] b12, input logic [7:0] b13, input logic [7:0] b23);
    for (int i = 0; i < 128; i++) pkt[i] = 8'($urandom);
    pkt[12] = b12;
    pkt[13] = b13;
    pkt[23] = b23;
  endtask

  task automatic run_exp(input logic [7:0] b12, input logic [7:0] b13, input logic [7:0] b23,
                         input exp_t e, input bit restart, input bit cfg_mid);
    bit seen;
    @(negedge clk);
    fill_pkt(b12, b13, b23);
    start = 1'b1;
    e.st = cyc;
    exp_q.push_back(e);
    @(negedge clk);
    start = restart;
    chk("busy", busy_o, 1'b1);
    if (cfg_mid) begin
      cfg_id = 3'd1; cfg_len = 8'd0; cfg_ts = 8'd0; cfg_tl = 3'd0; cfg_v = 4'b0;
      cfg_we = 1'b1;
    end
    @(negedge clk);
    start  = 1'b0;
    cfg_we = 1'b0;
    if (cfg_mid) chk("no_cfg_ack_busy", cfg_ack_o, 1'b0);
    seen = done_o;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = done_o;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: no done_o within 20 cycles (cycle %0d)", cyc);
      exp_q.delete();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    bit   seen;
    int   st;

    // {b12, b13, b23, restart, {valid, offsets, len, err, code, latency, start}}
    vecs[0] = '{8'h08, 8'h00, 8'h06, 1'b0, '{8'h07, {40'd0, 8'd34, 8'd14, 8'd0}, 8'd54, 1'b0, 2'd0, 4, 0}};
    vecs[1] = '{8'h86, 8'hDD, 8'h06, 1'b1, '{8'h01, 64'd0, 8'd14, 1'b0, 2'd0, 2, 0}};
    vecs[2] = '{8'h08, 8'h00, 8'h11, 1'b0, '{8'h03, {48'd0, 8'd14, 8'd0}, 8'd34, 1'b0, 2'd0, 3, 0}};
    vecs[3] = '{8'h08, 8'h01, 8'h06, 1'b0, '{8'h01, 64'd0, 8'd14, 1'b0, 2'd0, 2, 0}};
    vecs[4] = '{8'h08, 8'h00, 8'h06, 1'b1, '{8'h07, {40'd0, 8'd34, 8'd14, 8'd0}, 8'd54, 1'b0, 2'd0, 4, 0}};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", hdr_valid_o, 8'h00);
    chk("rst_offset", hdr_offset_o, 64'd0);
    chk("rst_len", parsed_len_o, 8'd0);
    chk("rst_err", err_o, 1'b0);
    chk("rst_code", err_code_o, 2'd0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_done", done_o, 1'b0);
    chk("rst_ack", cfg_ack_o, 1'b0);

    // Ethernet -> IPv4 -> TCP. Header 1 also has a lower-priority duplicate entry
    // (0x06 -> unconfigured 3) and an invalid entry for 0x11 that must never match.
    cfg_write(3'd0, 8'd14, 8'd12, 3'd2, 4'b0001, {16'h0, 16'h0, 16'h0, 16'h0800}, {3'd0, 3'd0, 3'd0, 3'd1});
    cfg_write(3'd1, 8'd20, 8'd9, 3'd1, 4'b0011, {16'h0, 16'h0011, 16'h0006, 16'h0006}, {3'd0, 3'd2, 3'd3, 3'd2});
    cfg_write(3'd2, 8'd20, 8'd0, 3'd0, 4'b0000, {16'h0, 16'h0, 16'h0, 16'h0}, {3'd0, 3'd0, 3'd0, 3'd0});

    // 32-byte buffer: header 1 would end at byte 34.
    @(negedge clk);
    fill_pkt(8'h08, 8'h00, 8'h06);
    start_s = 1'b1;
    st = cyc;
    @(negedge clk);
    start_s = 1'b0;
    chk("small_busy", busy_s, 1'b1);
    seen = done_s;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = done_s;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL small_done_timeout at cycle %0d", cyc);
    end else begin
      chk("oob_latency", 64'(cyc - st), 64'd3);
      chk("oob_valid", valid_s, 8'h01);
      chk("oob_offset", offs_s, 48'd0);
      chk("oob_len", len_s, 6'd14);
      chk("oob_err", err_s, 1'b1);
      chk("oob_code", code_s, 2'd1);
    end

    for (int i = 0; i < 5; i++)
      run_exp(vecs[i].b12, vecs[i].b13, vecs[i].b23, vecs[i].e, vecs[i].restart, 1'b0);

    // Config write while parsing must be dropped; a rerun must give the same result.
    run_exp(8'h08, 8'h00, 8'h06, vecs[0].e, 1'b0, 1'b1);
    run_exp(8'h08, 8'h00, 8'h06, vecs[0].e, 1'b0, 1'b0);

    // Loop: IPv4 points back to Ethernet; the third step hits header 0 again.
    cfg_write(3'd1, 8'd20, 8'd9, 3'd1, 4'b0001, {16'h0, 16'h0, 16'h0, 16'h0006}, {3'd0, 3'd0, 3'd0, 3'd0});
    e = '{8'h03, {48'd0, 8'd14, 8'd0}, 8'd34, 1'b1, 2'd2, 4, 0};
    run_exp(8'h08, 8'h00, 8'h06, e, 1'b0, 1'b0);

    // Reset mid-chain: no done pulse, everything back to zero, config wiped.
    @(negedge clk);
    fill_pkt(8'h08, 8'h00, 8'h06);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("pre_rst_busy", busy_o, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_valid", hdr_valid_o, 8'h00);
    chk("midrst_offset", hdr_offset_o, 64'd0);
    chk("midrst_len", parsed_len_o, 8'd0);
    chk("midrst_err", err_o, 1'b0);
    chk("midrst_busy", busy_o, 1'b0);
    repeat (6) @(negedge clk);
    chk("midrst_no_done", done_o, 1'b0);
    e = '{8'h00, 64'd0, 8'd0, 1'b1, 2'd3, 2, 0};
    run_exp(8'h08, 8'h00, 8'h06, e, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    chk("pending_results", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
